// File: rtl/bcd_updown_counter.sv
// BCD up/down counter, DIGITS decades, wrap or saturate at terminal.
// Optional parallel load with BCD sanitising: define BCD_LOAD_EN.
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_up,
`ifdef BCD_LOAD_EN
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_din,
    output logic                  o_load_err,
`endif
    output logic [4*DIGITS-1:0]   o_count,
    output logic                  o_tc
);

    logic [4*DIGITS-1:0] r_count;
    logic [4*DIGITS-1:0] w_next;
    logic [3:0]          w_dig;
    logic                w_all9;
    logic                w_all0;
    logic                w_term;
    logic                w_adv;

    // Ripple the "all lower digits at 9/0" enable through each decade.
    always_comb begin
        w_next = r_count;
        w_all9 = 1'b1;
        w_all0 = 1'b1;
        w_dig  = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_dig = r_count[4*k +: 4];
            if (i_up) begin
                if (w_all9) begin
                    w_next[4*k +: 4] = (w_dig == 4'd9) ?
                        4'd0 : w_dig + 4'd1;
                end
            end else begin
                if (w_all0) begin
                    w_next[4*k +: 4] = (w_dig == 4'd0) ?
                        4'd9 : w_dig - 4'd1;
                end
            end
            w_all9 = w_all9 & (w_dig == 4'd9);
            w_all0 = w_all0 & (w_dig == 4'd0);
        end
        w_term = i_up ? w_all9 : w_all0;
    end

    // Step unless saturating at the terminal value.
    assign w_adv = i_en & (WRAP | ~w_term);
    assign o_tc  = i_en & w_term;
    assign o_count = r_count;

`ifdef BCD_LOAD_EN
    logic [4*DIGITS-1:0] w_load_val;
    logic                w_load_bad;
    logic                r_load_err;

    // Replace any non-BCD nibble of the load value with zero.
    always_comb begin
        w_load_val = i_din;
        w_load_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (i_din[4*k +: 4] > 4'd9) begin
                w_load_val[4*k +: 4] = 4'd0;
                w_load_bad = 1'b1;
            end
        end
    end

    // Count register with load taking priority over counting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            if (i_load) begin
                r_count    <= w_load_val;
                r_load_err <= w_load_bad;
            end else if (w_adv) begin
                r_count <= w_next;
            end
        end
    end

    assign o_load_err = r_load_err;
`else
    // Count register; changes only by reset or counting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_adv) begin
            r_count <= w_next;
        end
    end
`endif

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits (legal 1..8).
REQ-002 Parameter WRAP, default 1: 1 = modulo-10^DIGITS wrap; 0 = saturate at terminal value.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; no count step when low.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe (BCD_LOAD_EN only).
REQ-008 din  input  4*DIGITS  load value, digit 0 in bits [3:0] (BCD_LOAD_EN only).
REQ-009 count  output  4*DIGITS  registered BCD count, digit 0 least significant.
REQ-010 tc  output  1  terminal count: combinational, high when en=1 and count at terminal for current direction.
REQ-011 load_err  output  1  registered, high one cycle after a load containing a non-BCD digit (BCD_LOAD_EN only).

Function
REQ-012 Every digit of count SHALL hold a value 0..9 at all times after reset.
REQ-013 Terminal value SHALL be all digits 9 when up=1 and all digits 0 when up=0.
REQ-014 With en=1, up=1: digit 0 SHALL increment; digit k SHALL step only when digits 0..k-1 are all 9; a stepping digit at 9 SHALL become 0.
REQ-015 With en=1, up=0: digit 0 SHALL decrement; digit k SHALL step only when digits 0..k-1 are all 0; a stepping digit at 0 SHALL become 9.
REQ-016 count SHALL reflect a step on the same rising edge that samples en=1 (latency 1 cycle, no additional pipeline lag).
REQ-017 At terminal with en=1: WRAP=1 SHALL wrap (99..9->00..0 up, 00..0->99..9 down); WRAP=0 SHALL hold count.
REQ-018 tc SHALL be asserted combinationally whenever en=1 and count equals the terminal value, independent of WRAP, for cascading into a following counter's en.
REQ-019 en=0 SHALL hold count and force tc=0.
REQ-020 Changing up with en=1 SHALL take effect on the same edge; no turnaround cycle.
REQ-021 Priority SHALL be rst > load > en.
REQ-022 A load SHALL write din into count on the next edge regardless of en and up; any digit >9 SHALL be loaded as 0 and load_err SHALL be 1 for the following cycle, otherwise load_err SHALL be 0.
REQ-023 load_err SHALL be 0 in every cycle not immediately following an erroneous load.

Reset
REQ-024 rst=1 SHALL immediately, without clock, force count to all zeros and load_err to 0.
REQ-025 Reset asserted mid-count SHALL discard the pending step; the first edge after release with en=1, up=1 SHALL produce count=00..01.
REQ-026 tc SHALL follow REQ-018 from reset value; with rst=1, en=1, up=0, tc SHALL read 1.

Configuration
REQ-027 Macro BCD_LOAD_EN SHALL compile in load, din and load_err with behaviour of REQ-021 to REQ-023.
REQ-028 Without BCD_LOAD_EN the load, din and load_err ports SHALL not exist and count SHALL change only by reset or counting.

Verification
REQ-029 DIGITS=4, WRAP=1, en=1, up=1 from reset, 10000 edges -> count passes 0009->0010, 0099->0100, 9999->0000; tc=1 exactly while count=9999.
REQ-030 DIGITS=4, WRAP=1, en=1, up=0 from reset -> first edge count=9999, then 9998; tc=1 only at 0000.
REQ-031 DIGITS=2, WRAP=0, up=1 from 98 -> 99 then holds 99 for 5 edges with tc=1; switch up=0 -> 98 next edge, tc=0.
REQ-032 BCD_LOAD_EN, load=1, en=1, din=0x12A7 -> count=1207, load_err=1 one cycle then 0; din=0x0456 -> count=0456, load_err=0.
REQ-033 Count to 0537, pulse rst asynchronously between edges -> count=0000 immediately; after release, en=1 up=1 -> 0001.
REQ-034 Two DIGITS=2 instances, second en driven by first tc, en=1 up=1, 150 edges -> concatenated value 0150, every digit 0..9 throughout.
